lsu_ctrl: RTL and testbench

Load/store controller that sits between the core's execute/memory stage and the word-addressed data memory. It accepts one RV32I load or store per request and translates byte addresses into word indices. Sub-word stores are done as read-modify-write, and load data is sign- or zero-extended. The controller is the initiator for the data memory's mem_read/mem_write/address/write_data/read_data interface and never asserts mem_read and mem_write together.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_ctrl_if.sv | 43 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store controller.
// Holds the controller state enum, the RV32I load/store width codes and a
// helper that classifies a width code as legal for a load or a store.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads; 011/110/111 are never legal.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bus interfaces of the load/store controller.
// lsu_req_if: core-side request/response channel (master = core, slave = LSU).
// lsu_mem_if: data-memory port (master = LSU, slave = memory); the memory
// answers mem_read_data combinationally and writes on the rising edge.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport master (
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport slave (
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store controller.
// rdata_o  = addressed lane of word_i, sign/zero extended per funct3.
// merged_o = word_i with the addressed lane replaced by the low bits of
//            wdata_i (whole wdata_i for a word access).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it for the load result.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
      F3_H:    rdata_o = {{16{half_s[15]}}, half_s};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {24'd0, byte_s};
      F3_HU:   rdata_o = {16'd0, half_s};
      default: rdata_o = 32'd0;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B, F3_BU: begin
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          2'd3:    merged_o[31:24] = wdata_i[7:0];
          default: merged_o = word_i;
        endcase
      end
      F3_H, F3_HU: begin
        if (addr_lo_i[1]) begin
          merged_o[31:16] = wdata_i[15:0];
        end else begin
          merged_o[15:0] = wdata_i[15:0];
        end
      end
      F3_W:    merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller in front of a word-addressed memory.
// Loads: IDLE->RD->RESP. Word stores: IDLE->WR->RESP. Byte/half stores are
// read-modify-write: IDLE->RD->WR->RESP. Errored requests go IDLE->RESP
// without touching memory. All outputs are registered state decodes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// H/HU/W accesses are errors; otherwise the low address bits are cleared.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  // Byte-address bits that fall inside the memory.
  localparam int AW = DEPTH_LOG2 + 2;

  lsu_state_e      state_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic            req_ready_q;
  logic            resp_valid_q;
  logic [31:0]     resp_rdata_q;
  logic            resp_err_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [31:0]     mem_address_q;
  logic [31:0]     mem_write_data_q;

  logic            accept_s;
  logic            misalign_s;
  logic            misalign_err_s;
  logic            range_err_s;
  logic            err_s;
  logic [AW-1:0]   addr_eff_s;
  logic [31:0]     word_idx_s;
  logic [31:0]     word_idx_q_s;
  logic [31:0]     rdata_s;
  logic [31:0]     merged_s;

  // Request classification: alignment, range and width-code checks.
  always_comb begin
    accept_s   = req.req_valid && req_ready_q;
    addr_eff_s = req.req_addr[AW-1:0];
    case (req.req_funct3)
      F3_H, F3_HU: misalign_s = req.req_addr[0];
      F3_W:        misalign_s = |req.req_addr[1:0];
      default:     misalign_s = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err_s = misalign_s;
`else
    misalign_err_s = 1'b0;
    case (req.req_funct3)
      F3_H, F3_HU: addr_eff_s[0]   = 1'b0;
      F3_W:        addr_eff_s[1:0] = 2'b00;
      default:     addr_eff_s      = req.req_addr[AW-1:0];
    endcase
`endif
    range_err_s  = |req.req_addr[31:AW];
    err_s        = ~f3_legal(req.req_we, req.req_funct3) | range_err_s | misalign_err_s;
    word_idx_s   = {{(32-DEPTH_LOG2){1'b0}}, addr_eff_s[AW-1:2]};
    word_idx_q_s = {{(32-DEPTH_LOG2){1'b0}}, addr_q[AW-1:2]};
  end

  lsu_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .word_i    (mem.mem_read_data),
    .wdata_i   (wdata_q),
    .rdata_o   (rdata_s),
    .merged_o  (merged_s)
  );

  // Controller FSM with request latches and registered bus/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      we_q             <= 1'b0;
      funct3_q         <= 3'd0;
      addr_q           <= '0;
      wdata_q          <= 32'd0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'd0;
      resp_err_q       <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            we_q        <= req.req_we;
            funct3_q    <= req.req_funct3;
            addr_q      <= addr_eff_s;
            wdata_q     <= req.req_wdata;
            req_ready_q <= 1'b0;
            if (err_s) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req.req_we || (req.req_funct3 != F3_W)) begin
              state_q       <= ST_RD;
              mem_read_q    <= 1'b1;
              mem_address_q <= word_idx_s;
            end else begin
              state_q          <= ST_WR;
              mem_write_q      <= 1'b1;
              mem_address_q    <= word_idx_s;
              mem_write_data_q <= req.req_wdata;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          mem_read_q <= 1'b0;
          if (we_q) begin
            state_q          <= ST_WR;
            mem_write_q      <= 1'b1;
            mem_address_q    <= word_idx_q_s;
            mem_write_data_q <= merged_s;
          end else begin
            state_q       <= ST_RESP;
            mem_address_q <= 32'd0;
            resp_valid_q  <= 1'b1;
            resp_rdata_q  <= rdata_s;
          end
        end
        ST_WR: begin
          state_q          <= ST_RESP;
          mem_write_q      <= 1'b0;
          mem_address_q    <= 32'd0;
          mem_write_data_q <= 32'd0;
          resp_valid_q     <= 1'b1;
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q          <= ST_IDLE;
          req_ready_q      <= 1'b1;
          resp_valid_q     <= 1'b0;
          resp_rdata_q     <= 32'd0;
          resp_err_q       <= 1'b0;
          mem_read_q       <= 1'b0;
          mem_write_q      <= 1'b0;
          mem_address_q    <= 32'd0;
          mem_write_data_q <= 32'd0;
        end
      endcase
    end
  end

  assign req.req_ready      = req_ready_q;
  assign req.resp_valid     = resp_valid_q;
  assign req.resp_rdata     = resp_rdata_q;
  assign req.resp_err       = resp_err_q;
  assign mem.mem_read       = mem_read_q;
  assign mem.mem_write      = mem_write_q;
  assign mem.mem_address    = mem_address_q;
  assign mem.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus randomized bench for lsu_ctrl with a behavioural
// memory and an arithmetic reference model of the load/store rules.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];

  lsu_req_if req_if ();
  lsu_mem_if mem_if ();

  lsu_ctrl #(.DEPTH_LOG2(8)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_if.slave),
    .mem (mem_if.master)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  assign mem_if.mem_read_data = dmem[mem_if.mem_address[7:0]];
  always @(posedge clk) begin
    if (mem_if.mem_write) dmem[mem_if.mem_address[7:0]] <= mem_if.mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    bad = !((f3 inside {3'b000, 3'b001, 3'b010}) || (!we && (f3 inside {3'b100, 3'b101})));
    if (addr >= 32'h400) bad = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 inside {3'b001, 3'b101}) && (addr % 32'd2 != 32'd0)) bad = 1'b1;
    if ((f3 == 3'b010) && (addr % 32'd4 != 32'd0)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
`ifndef LSU_MISALIGN_TRAP_EN
    if (f3 inside {3'b001, 3'b101}) a = addr - (addr % 32'd2);
    if (f3 == 3'b010) a = addr - (addr % 32'd4);
`endif
    return a;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] word, input int off);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (8 * (off - off % 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [31:0] wd, input int off);
    logic [31:0] mask;
    int sh;
    if (f3 == 3'b010) return wd;
    sh   = (f3 == 3'b000) ? 8 * off : 8 * (off - off % 2);
    mask = ((f3 == 3'b000) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // One request on the bus; records strobes and the response, bounded wait.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int rd_n, output int wr_n,
                        output logic [31:0] rd_a, output logic [31:0] wr_a,
                        output logic [31:0] wr_d, output logic err, output logic [31:0] rdata);
    lat = 0; rd_n = 0; wr_n = 0; rd_a = 32'd0; wr_a = 32'd0; wr_d = 32'd0;
    err = 1'b0; rdata = 32'd0;
    @(negedge clk);
    chk({tag, ":ready"}, 32'(req_if.req_ready), 32'd1);
    req_if.req_valid  = 1'b1;
    req_if.req_we     = we;
    req_if.req_funct3 = f3;
    req_if.req_addr   = addr;
    req_if.req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_if.req_valid  = $urandom_range(0, 1) == 1;
    req_if.req_we     = $urandom_range(0, 1) == 1;
    req_if.req_funct3 = 3'($urandom_range(0, 7));
    req_if.req_addr   = $urandom();
    req_if.req_wdata  = $urandom();
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_if.mem_read && mem_if.mem_write) chk({tag, ":both_strobes"}, 32'd1, 32'd0);
      if (mem_if.mem_read) begin rd_n++; rd_a = mem_if.mem_address; end
      if (mem_if.mem_write) begin wr_n++; wr_a = mem_if.mem_address; wr_d = mem_if.mem_write_data; end
      if (!mem_if.mem_read && !mem_if.mem_write)
        chk({tag, ":idle_bus"}, mem_if.mem_address | mem_if.mem_write_data, 32'd0);
      chk({tag, ":busy"}, 32'(req_if.req_ready), 32'd0);
      if (req_if.resp_valid) begin lat = c; err = req_if.resp_err; rdata = req_if.resp_rdata; end
    end
    req_if.req_valid = 1'b0;
    if (lat == 0) chk({tag, ":timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, ":pulse"}, 32'(req_if.resp_valid), 32'd0);
  endtask

  // Request plus comparison against the reference model.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic [31:0] got_wd);
    int lat, rd_n, wr_n, idx, off, e_lat;
    logic [31:0] rd_a, wr_a, eff, e_wd;
    logic err, e_err;
    e_err = ref_err(we, f3, addr);
    eff   = ref_align(f3, addr);
    idx   = int'(eff / 32'd4) % 256;
    off   = int'(eff % 32'd4);
    do_req(tag, we, f3, addr, wdata, lat, rd_n, wr_n, rd_a, wr_a, got_wd, err, got_rdata);
    chk({tag, ":err"}, 32'(err), 32'(e_err));
    if (e_err) begin
      chk({tag, ":lat"}, 32'(lat), 32'd1);
      chk({tag, ":strobes"}, 32'(rd_n + wr_n), 32'd0);
      chk({tag, ":rdata"}, got_rdata, 32'd0);
    end else if (!we) begin
      chk({tag, ":lat"}, 32'(lat), 32'd2);
      chk({tag, ":rd_n"}, 32'(rd_n), 32'd1);
      chk({tag, ":wr_n"}, 32'(wr_n), 32'd0);
      chk({tag, ":rd_a"}, rd_a, 32'(idx));
      chk({tag, ":rdata"}, got_rdata, ref_load(f3, ref_mem[idx], off));
    end else begin
      e_lat = (f3 == 3'b010) ? 2 : 3;
      e_wd  = ref_store(f3, ref_mem[idx], wdata, off);
      chk({tag, ":lat"}, 32'(lat), 32'(e_lat));
      chk({tag, ":rd_n"}, 32'(rd_n), (f3 == 3'b010) ? 32'd0 : 32'd1);
      chk({tag, ":wr_n"}, 32'(wr_n), 32'd1);
      chk({tag, ":wr_a"}, wr_a, 32'(idx));
      chk({tag, ":wr_d"}, got_wd, e_wd);
      chk({tag, ":rdata"}, got_rdata, 32'd0);
      ref_mem[idx] = e_wd;
      chk({tag, ":mem"}, dmem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] rd, wd, addr;
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic        we;
    int          kind;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_if.req_valid = 1'b0; req_if.req_we = 1'b0; req_if.req_funct3 = 3'd0;
    req_if.req_addr = 32'd0; req_if.req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    chk("rst:req_ready", 32'(req_if.req_ready), 32'd1);
    chk("rst:resp_valid", 32'(req_if.resp_valid), 32'd0);
    chk("rst:resp_rdata", req_if.resp_rdata, 32'd0);
    chk("rst:resp_err", 32'(req_if.resp_err), 32'd0);
    chk("rst:strobes", {30'd0, mem_if.mem_read, mem_if.mem_write}, 32'd0);
    chk("rst:addr", mem_if.mem_address, 32'd0);
    chk("rst:wdata", mem_if.mem_write_data, 32'd0);
    rst = 1'b0;

    // Fill words 0..15 with known data.
    for (int i = 0; i < 16; i++) run_op("init_sw", 1'b1, 3'b010, 32'(4 * i), $urandom(), rd, wd);

    // Directed sequence.
    run_op("sw_14", 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, rd, wd);
    chk("sw_14:data", wd, 32'hDEADBEEF);
    run_op("lb_17", 1'b0, 3'b000, 32'h17, 32'd0, rd, wd);
    chk("lb_17:val", rd, 32'hFFFFFFDE);
    run_op("lbu_17", 1'b0, 3'b100, 32'h17, 32'd0, rd, wd);
    chk("lbu_17:val", rd, 32'h000000DE);
    run_op("lh_14", 1'b0, 3'b001, 32'h14, 32'd0, rd, wd);
    chk("lh_14:val", rd, 32'hFFFFBEEF);
    run_op("lhu_16", 1'b0, 3'b101, 32'h16, 32'd0, rd, wd);
    chk("lhu_16:val", rd, 32'h0000DEAD);
    run_op("sb_15", 1'b1, 3'b000, 32'h15, 32'h00000012, rd, wd);
    chk("sb_15:data", wd, 32'hDEAD12EF);
    run_op("lw_14", 1'b0, 3'b010, 32'h14, 32'd0, rd, wd);
    chk("lw_14:val", rd, 32'hDEAD12EF);
    run_op("lw_400", 1'b0, 3'b010, 32'h400, 32'd0, rd, wd);
    run_op("f3_011", 1'b0, 3'b011, 32'h10, 32'd0, rd, wd);
    run_op("sbu", 1'b1, 3'b100, 32'h10, 32'h55, rd, wd);
    run_op("lw_16", 1'b0, 3'b010, 32'h16, 32'd0, rd, wd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_16:val", rd, 32'd0);
`else
    chk("lw_16:val", rd, 32'hDEAD12EF);
`endif

    // Reset in the middle of a halfword store's write cycle.
    @(negedge clk);
    req_if.req_valid = 1'b1; req_if.req_we = 1'b1; req_if.req_funct3 = 3'b001;
    req_if.req_addr = 32'h8; req_if.req_wdata = 32'h0000A5A5;
    @(posedge clk);
    #1 req_if.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wr:rd_phase", 32'(mem_if.mem_read), 32'd1);
    @(negedge clk);
    chk("rst_wr:wr_phase", 32'(mem_if.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr:strobes", {30'd0, mem_if.mem_read, mem_if.mem_write}, 32'd0);
    chk("rst_wr:addr", mem_if.mem_address, 32'd0);
    chk("rst_wr:ready", 32'(req_if.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wr:mem", dmem[2], ref_mem[2]);
    run_op("rst_wr:lw_8", 1'b0, 3'b010, 32'h8, 32'd0, rd, wd);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 15));
      we   = $urandom_range(0, 1) == 1;
      f3   = we ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
      if (kind == 0) f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
      if (kind == 1) addr = $urandom() | 32'h400;
      run_op("rand", we, f3, addr, $urandom(), rd, wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
